sram_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port synchronous SRAM (`sram`, ADDR_WIDTH/DATA_WIDTH as in the ip_lib RAMs) between two masters. Each master issues read/write beats with a req/gnt handshake. The arbiter grants with round-robin plus a bounded burst, registers the winning command onto the SRAM pins, and returns read data with a per-requester valid strobe. It sits between the ip_lib SRAM and any two clients that would otherwise need the dual-port part.

---
 rtl/sram_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Purpose : two-requester arbiter sharing one single-port synchronous SRAM;
//           round-robin with bounded burst, or strict priority when
//           SRAM_ARB_FIXED_PRIO_EN is defined.
// Latency : gnt is combinational; command on SRAM pins 1 cycle after the
//           accepting edge; rvalid/rdata 2 cycles after the accepting edge.
// Backpressure: a requester holds req/we/addr/wdata until it sees gnt high;
//           one beat per cycle is accepted when a requester is granted.
// Ports   : clk, rst (async active-high); reqN/weN/addrN/wdataN requests;
//           gntN grant; rvalidN/rdataN read return; sram_* SRAM pins.
module sram_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  sram_csen_n,
    output logic                  sram_wren_n,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state_q, state_d;
    logic   win_vld;
    logic   win_id;

`ifndef SRAM_ARB_FIXED_PRIO_EN
    // Counter wide enough for MAX_BURST-1; at least one bit so MAX_BURST=1 works.
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          burst_done;

    assign burst_done = (cnt_q == CNT_MAX);
`endif

    // Winner selection
    always_comb begin
        win_vld = 1'b0;
        win_id  = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        // Strict priority: the owner state carries no weight in the decision.
        case (state_q)
            default: begin
                if (req0) begin
                    win_vld = 1'b1;
                    win_id  = 1'b0;
                end else if (req1) begin
                    win_vld = 1'b1;
                    win_id  = 1'b1;
                end
            end
        endcase
`else
        case (state_q)
            OWN0: begin
                if (req0) begin
                    win_vld = 1'b1;
                    win_id  = burst_done && req1;   // preempt at end of burst
                end else if (req1) begin
                    win_vld = 1'b1;
                    win_id  = 1'b1;
                end
            end
            OWN1: begin
                if (req1) begin
                    win_vld = 1'b1;
                    win_id  = !(burst_done && req0);
                end else if (req0) begin
                    win_vld = 1'b1;
                    win_id  = 1'b0;
                end
            end
            default: begin
                if (req0 && req1) begin
                    win_vld = 1'b1;
                    win_id  = ~last_q;
                end else if (req0) begin
                    win_vld = 1'b1;
                    win_id  = 1'b0;
                end else if (req1) begin
                    win_vld = 1'b1;
                    win_id  = 1'b1;
                end
            end
        endcase
`endif
    end

    assign gnt0 = win_vld && !win_id;
    assign gnt1 = win_vld &&  win_id;

    // Next state, owner memory and burst counter
    always_comb begin
        state_d = IDLE;
        if (win_vld) begin
            state_d = win_id ? OWN1 : OWN0;
        end
`ifndef SRAM_ARB_FIXED_PRIO_EN
        last_d = win_vld ? win_id : last_q;
        cnt_d  = '0;
        // Repeat grant to the current owner counts up and saturates.
        if (win_vld && ((state_q == OWN0 && !win_id) || (state_q == OWN1 && win_id))) begin
            cnt_d = burst_done ? cnt_q : cnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;   // requester 0 wins the first tie after reset
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Command stage: registered SRAM pins
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    assign win_we    = win_id ? we1    : we0;
    assign win_addr  = win_id ? addr1  : addr0;
    assign win_wdata = win_id ? wdata1 : wdata0;

    logic                  csen_n_q;
    logic                  wren_n_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csen_n_q <= 1'b1;
            wren_n_q <= 1'b1;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            csen_n_q <= ~win_vld;
            wren_n_q <= win_vld ? ~win_we : 1'b1;
            if (win_vld) begin
                addr_q <= win_addr;
                din_q  <= win_wdata;
            end
        end
    end

    assign sram_csen_n = csen_n_q;
    assign sram_wren_n = wren_n_q;
    assign sram_addr   = addr_q;
    assign sram_din    = din_q;

    // Read return: stage 1 covers the command cycle, stage 2 the data cycle.
    logic rd1_vld_q, rd1_id_q;
    logic rd2_vld_q, rd2_id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1_vld_q <= 1'b0;
            rd1_id_q  <= 1'b0;
            rd2_vld_q <= 1'b0;
            rd2_id_q  <= 1'b0;
        end else begin
            rd1_vld_q <= win_vld && !win_we;
            rd1_id_q  <= win_id;
            rd2_vld_q <= rd1_vld_q;
            rd2_id_q  <= rd1_id_q;
        end
    end

    assign rvalid0 = rd2_vld_q && !rd2_id_q;
    assign rvalid1 = rd2_vld_q &&  rd2_id_q;
    assign rdata0  = sram_dout;
    assign rdata1  = sram_dout;

endmodule

// File: tb/tb_sram_arbiter.sv
// Purpose : directed, self-checking bench for sram_arbiter with a behavioural
//           single-port SRAM; inputs change 1 time unit after posedge and
//           outputs are observed at that same point.
// Ports   : none (top-level bench).
module tb_sram_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          sram_csen_n, sram_wren_n;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .sram_csen_n(sram_csen_n), .sram_wren_n(sram_wren_n),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // Behavioural single-port synchronous SRAM
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!sram_csen_n) begin
            if (!sram_wren_n) mem[sram_addr] <= sram_din;
            else              sram_dout      <= mem[sram_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        req0 = 1; we0 = 0; addr0 = 4'd5;
        step();                      // read accepted at this edge
        req0 = 0;
        rst  = 1'b1;                 // assert before the SRAM edge
        #1;
        tests_run++;
        if ({sram_csen_n, sram_wren_n, rvalid0, rvalid1} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL reset_async: csen,wren,rv0,rv1=%b required 1100",
                     {sram_csen_n, sram_wren_n, rvalid0, rvalid1});
        end
        repeat (3) step();
        tests_run++;
        if ({sram_csen_n, sram_wren_n, sram_addr, sram_din, rvalid0, rvalid1, gnt0, gnt1}
            !== {1'b1, 1'b1, 4'h0, 8'h00, 4'b0000}) begin
            tests_failed++;
            $display("FAIL reset_values: csen=%b wren=%b addr=%h din=%h rv=%b%b gnt=%b%b",
                     sram_csen_n, sram_wren_n, sram_addr, sram_din, rvalid0, rvalid1, gnt0, gnt1);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if ({rvalid0, rvalid1} !== 2'b00) begin
                tests_failed++;
                $display("FAIL reset_no_rvalid[%0d]: rv=%b%b required 00", i, rvalid0, rvalid1);
            end
        end
    endtask

    task automatic test_single_write_read();
        do_reset();
        req0 = 1; we0 = 1; addr0 = 4'd3; wdata0 = 8'h5A;
        #1;
        tests_run++;
        if ({gnt0, gnt1} !== 2'b10) begin
            tests_failed++;
            $display("FAIL single_wr_gnt: gnt=%b%b required 10", gnt0, gnt1);
        end
        step();
        // Read of the same address issued back-to-back with the write.
        we0 = 0;
        #1;
        tests_run++;
        if ({sram_csen_n, sram_wren_n, sram_addr, sram_din} !== {1'b0, 1'b0, 4'd3, 8'h5A}) begin
            tests_failed++;
            $display("FAIL single_wr_cmd: csen=%b wren=%b addr=%h din=%h required 0 0 3 5a",
                     sram_csen_n, sram_wren_n, sram_addr, sram_din);
        end
        tests_run++;
        if (gnt0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_rd_gnt: gnt0=%b required 1", gnt0);
        end
        step();
        req0 = 0;
        tests_run++;
        if ({sram_csen_n, sram_wren_n, sram_addr, rvalid0} !== {1'b0, 1'b1, 4'd3, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_rd_cmd: csen=%b wren=%b addr=%h rv0=%b required 0 1 3 0",
                     sram_csen_n, sram_wren_n, sram_addr, rvalid0);
        end
        step();
        tests_run++;
        if ({rvalid0, rvalid1, rdata0, sram_csen_n} !== {2'b10, 8'h5A, 1'b1}) begin
            tests_failed++;
            $display("FAIL single_rd_data: rv=%b%b rdata0=%h csen=%b required 10 5a 1",
                     rvalid0, rvalid1, rdata0, sram_csen_n);
        end
        step();
        tests_run++;
        if ({rvalid0, rvalid1} !== 2'b00) begin
            tests_failed++;
            $display("FAIL single_rd_pulse: rv=%b%b required 00", rvalid0, rvalid1);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        do_reset();
        req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        addr0 = 4'd8; addr1 = 4'd9; wdata0 = 8'hA0; wdata1 = 8'hB1;
        for (int i = 0; i < 16; i++) begin
            #1;
            exp_g = (((i / 4) % 2) == 0) ? 2'b10 : 2'b01;
            tests_run++;
            if ({gnt0, gnt1} !== exp_g) begin
                tests_failed++;
                $display("FAIL contention[%0d]: gnt=%b%b required %b", i, gnt0, gnt1, exp_g);
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_handover();
        logic [1:0] exp_g [0:6];
        exp_g = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        do_reset();
        we0 = 1; we1 = 1; addr0 = 4'd10; addr1 = 4'd11;
        for (int i = 0; i < 7; i++) begin
            req0 = (i != 2);
            req1 = (i >= 2);
            #1;
            tests_run++;
            if ({gnt0, gnt1} !== exp_g[i]) begin
                tests_failed++;
                $display("FAIL handover[%0d]: gnt=%b%b required %b", i, gnt0, gnt1, exp_g[i]);
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_interleaved_reads();
        do_reset();
        // Preload through the arbiter.
        req0 = 1; we0 = 1; addr0 = 4'd1; wdata0 = 8'h11;
        #1;
        tests_run++;
        if ({gnt0, gnt1} !== 2'b10) begin
            tests_failed++;
            $display("FAIL preload0_gnt: gnt=%b%b required 10", gnt0, gnt1);
        end
        step();
        req0 = 0; req1 = 1; we1 = 1; addr1 = 4'd2; wdata1 = 8'h22;
        #1;
        tests_run++;
        if ({gnt0, gnt1} !== 2'b01) begin
            tests_failed++;
            $display("FAIL preload1_gnt: gnt=%b%b required 01", gnt0, gnt1);
        end
        step();
        we0 = 0; we1 = 0;
        for (int s = 0; s < 6; s++) begin
            req0 = (s == 0 || s == 2);
            req1 = (s == 1 || s == 3);
            #1;
            tests_run++;
            if ({rvalid0, rvalid1} !== {(s == 2 || s == 4), (s == 3 || s == 5)}) begin
                tests_failed++;
                $display("FAIL interleave_rv[%0d]: rv=%b%b", s, rvalid0, rvalid1);
            end
            if (s == 2 || s == 4) begin
                tests_run++;
                if (rdata0 !== 8'h11) begin
                    tests_failed++;
                    $display("FAIL interleave_rd0[%0d]: rdata0=%h required 11", s, rdata0);
                end
            end
            if (s == 3 || s == 5) begin
                tests_run++;
                if (rdata1 !== 8'h22) begin
                    tests_failed++;
                    $display("FAIL interleave_rd1[%0d]: rdata1=%h required 22", s, rdata1);
                end
            end
            step();
        end
        clear_inputs();
    endtask

`ifdef SRAM_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        do_reset();
        req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            tests_run++;
            if ({gnt0, gnt1} !== 2'b10) begin
                tests_failed++;
                $display("FAIL fixed_prio[%0d]: gnt=%b%b required 10", i, gnt0, gnt1);
            end
            step();
        end
        req0 = 0;
        #1;
        tests_run++;
        if ({gnt0, gnt1} !== 2'b01) begin
            tests_failed++;
            $display("FAIL fixed_prio_release: gnt=%b%b required 01", gnt0, gnt1);
        end
        step();
        clear_inputs();
    endtask
`endif

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_single_write_read();
`ifdef SRAM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_contention();
        test_handover();
`endif
        test_interleaved_reads();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
